// File: rtl/ahb_lsu_master_if.sv
// Core LSU request/response channel plus the AHB-lite bus, seen from the LSU master.
interface ahb_lsu_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Core-side request/response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [2:0]            req_rwtyp;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // AHB-lite side
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  // The LSU master block
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_rwtyp,
    input  hready, hresp, hrdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output hsel, haddr, hwrite, hsize, hwdata
  );

  // Environment: core driving requests and the AHB responder
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_rwtyp,
    output hready, hresp, hrdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hsel, haddr, hwrite, hsize, hwdata
  );
endinterface

// File: rtl/ahb_lsu_master.sv
// AHB-lite initiator: one LSU load/store request becomes one AHB transfer,
// with store lane replication, load extraction/extension, alignment checks
// and a data-phase timeout.
module ahb_lsu_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  ahb_lsu_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  hsel_q,      hsel_d;
  logic [ADDR_WIDTH-1:0] haddr_q,     haddr_d;
  logic                  hwrite_q,    hwrite_d;
  logic [2:0]            hsize_q,     hsize_d;
  logic [DATA_WIDTH-1:0] hwdata_q,    hwdata_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [2:0]            rwtyp_q,     rwtyp_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;

  logic                  req_illegal;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  // Request legality: encoding, unsigned stores, natural alignment
  always_comb begin
    req_illegal = 1'b0;
    unique case (bus.req_rwtyp)
      3'b000, 3'b010, 3'b001: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = bus.req_we;
      default:                req_illegal = 1'b1;
    endcase
    if (bus.req_rwtyp[1:0] == 2'b01 && bus.req_addr[0]) begin
      req_illegal = 1'b1;
    end
    if (bus.req_rwtyp[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) begin
      req_illegal = 1'b1;
    end
  end

  // Store data replicated into every lane of its access size
  always_comb begin
    unique case (rwtyp_q[1:0])
      2'b00:   store_lanes = {4{wdata_q[7:0]}};
      2'b01:   store_lanes = {2{wdata_q[15:0]}};
      default: store_lanes = wdata_q;
    endcase
  end

  // Load lane selection by address and sign/zero extension by type
  always_comb begin
    ld_byte = 8'(bus.hrdata >> {haddr_q[1:0], 3'b000});
    ld_half = haddr_q[1] ? bus.hrdata[31:16] : bus.hrdata[15:0];
    unique case (rwtyp_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h000000, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0000, ld_half};
      default: load_data = bus.hrdata;
    endcase
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    hsel_d      = hsel_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    cnt_d       = cnt_q;
    rwtyp_d     = rwtyp_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          rwtyp_d = bus.req_rwtyp;
          wdata_d = bus.req_wdata;
          if (req_illegal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = S_ADDR;
            hsel_d   = 1'b1;
            haddr_d  = bus.req_addr;
            hwrite_d = bus.req_we;
            hsize_d  = {1'b0, bus.req_rwtyp[1:0]};
          end
        end
      end
      S_ADDR: begin
        state_d  = S_DATA;
        hwdata_d = hwrite_q ? store_lanes : '0;
      end
      S_DATA: begin
        if (bus.hready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.hresp;
          rsp_rdata_d = (bus.hresp || hwrite_q) ? '0 : load_data;
          hsel_d      = 1'b0;
          hwrite_d    = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          hsel_d      = 1'b0;
          hwrite_d    = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers, asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      cnt_q       <= '0;
      rwtyp_q     <= 3'b000;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      hsel_q      <= hsel_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      cnt_q       <= cnt_d;
      rwtyp_q     <= rwtyp_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.hsel      = hsel_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Self-checking bench for ahb_lsu_master: directed scenarios plus randomized
// transfers compared against a behavioural model of the request semantics.
module tb_ahb_lsu_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int TO = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ahb_lsu_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_lsu_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the most recent transfer (cycle numbers relative to accept edge T)
  int          ob_lat, ob_hs_first, ob_hs_last, ob_nvalid;
  logic [31:0] ob_rdata, ob_hwdata, ob_haddr;
  logic        ob_err, ob_hwrite, ob_ready, ob_hold;
  logic [2:0]  ob_hsize;

  typedef struct {
    logic        illegal;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] hwdata;
  } exp_t;

  // Reference: what the spec says a request should produce
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] typ, input int waits, input logic resp_e,
                                 input logic [31:0] rd);
    exp_t        e;
    int          nbytes, low, shift;
    logic [31:0] mask, val;
    nbytes    = 1 << (typ % 4);
    low       = int'(addr[1:0]);
    e.illegal = !(typ == 0 || typ == 1 || typ == 2 || typ == 4 || typ == 5) ||
                (we && typ >= 4) || ((low % nbytes) != 0);
    mask      = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    shift     = 8 * (low - (low % nbytes));
    val       = (rd >> shift) & mask;
    if (typ < 4 && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
    if (nbytes == 1)      e.hwdata = (wdata & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) e.hwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
    else                  e.hwdata = wdata;
    if (e.illegal) begin
      e.lat = 1; e.err = 1'b1; e.rdata = 32'h0;
    end else if (waits >= TO) begin
      e.lat = 2 + TO; e.err = 1'b1; e.rdata = 32'h0;
    end else begin
      e.lat   = 3 + waits;
      e.err   = resp_e;
      e.rdata = (resp_e || we) ? 32'h0 : val;
    end
    return e;
  endfunction

  // Drive one request and act as the AHB responder; record what the DUT did
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] typ, input int waits, input logic resp_e,
                         input logic [31:0] rd);
    int nhs;
    nhs = 0;
    ob_lat = -1; ob_hs_first = -1; ob_hs_last = -1; ob_nvalid = 0;
    ob_rdata = 32'h0; ob_err = 1'b0; ob_hwdata = 32'h0; ob_haddr = 32'h0;
    ob_hwrite = 1'b0; ob_hsize = 3'b111; ob_hold = 1'b0;
    @(negedge clk);
    ob_ready      = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rwtyp = typ;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.hsel) begin
        nhs++;
        if (ob_hs_first < 0) ob_hs_first = c;
        ob_hs_last = c;
        if (nhs == 1) begin
          ob_hsize  = bus.hsize;
          ob_haddr  = bus.haddr;
          ob_hwrite = bus.hwrite;
          bus.hready = 1'($urandom_range(0, 1));
        end else begin
          if (nhs == 2) ob_hwdata = bus.hwdata;
          if (nhs - 1 > waits) begin
            bus.hready = 1'b1;
            bus.hresp  = resp_e;
            bus.hrdata = rd;
          end else begin
            bus.hready = 1'b0;
            bus.hresp  = 1'($urandom_range(0, 1));
            bus.hrdata = $urandom;
          end
        end
      end else begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
      end
      if (bus.rsp_valid) begin
        ob_nvalid++;
        if (ob_lat < 0) begin
          ob_lat   = c;
          ob_rdata = bus.rsp_rdata;
          ob_err   = bus.rsp_err;
        end
      end
      if (ob_lat > 0 && c == ob_lat + 1) begin
        ob_hold = (bus.rsp_rdata === ob_rdata) && (bus.rsp_err === ob_err);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rwtyp = 3'b010;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    repeat (3) @(negedge clk);
    tests++; if ({bus.hsel, bus.hwrite, bus.rsp_valid, bus.rsp_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b expected 0000", {bus.hsel, bus.hwrite, bus.rsp_valid, bus.rsp_err}); end
    tests++; if ({bus.haddr, bus.hsize, bus.hwdata, bus.rsp_rdata} !== 99'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h expected 0", bus.haddr, bus.hsize, bus.hwdata, bus.rsp_rdata); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_lw();
    run_txn(1'b0, 32'h100, 32'h0, 3'b010, 0, 1'b0, 32'h89AB_CDEF);
    tests++; if (ob_ready !== 1'b1) begin fails++; $display("FAIL lw_ready got %b expected 1", ob_ready); end
    tests++; if (ob_hs_first !== 1 || ob_hs_last !== 2) begin
      fails++; $display("FAIL lw_hsel_window got %0d..%0d expected 1..2", ob_hs_first, ob_hs_last); end
    tests++; if (ob_hsize !== 3'd2 || ob_haddr !== 32'h100 || ob_hwrite !== 1'b0) begin
      fails++; $display("FAIL lw_addr_phase got size %0d addr %h wr %b expected 2 100 0", ob_hsize, ob_haddr, ob_hwrite); end
    tests++; if (ob_lat !== 3) begin fails++; $display("FAIL lw_latency got %0d expected 3", ob_lat); end
    tests++; if (ob_rdata !== 32'h89AB_CDEF || ob_err !== 1'b0) begin
      fails++; $display("FAIL lw_rdata got %h err %b expected 89abcdef err 0", ob_rdata, ob_err); end
    tests++; if (ob_nvalid !== 1 || ob_hold !== 1'b1) begin
      fails++; $display("FAIL lw_pulse got count %0d hold %b expected 1 1", ob_nvalid, ob_hold); end
  endtask

  task automatic test_load_ext();
    run_txn(1'b0, 32'h203, 32'h0, 3'b000, 0, 1'b0, 32'h8011_2233);
    tests++; if (ob_rdata !== 32'hFFFF_FF80 || ob_hsize !== 3'd0) begin
      fails++; $display("FAIL lb_sign got %h size %0d expected ffffff80 0", ob_rdata, ob_hsize); end
    run_txn(1'b0, 32'h202, 32'h0, 3'b101, 0, 1'b0, 32'h8011_2233);
    tests++; if (ob_rdata !== 32'h0000_8011 || ob_hsize !== 3'd1) begin
      fails++; $display("FAIL lhu_zero got %h size %0d expected 00008011 1", ob_rdata, ob_hsize); end
  endtask

  task automatic test_store_wait();
    run_txn(1'b1, 32'h301, 32'h0000_00A5, 3'b000, 3, 1'b0, 32'hDEAD_BEEF);
    tests++; if (ob_hwdata !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL sb_hwdata got %h expected a5a5a5a5", ob_hwdata); end
    tests++; if (ob_hwrite !== 1'b1 || ob_hsize !== 3'd0) begin
      fails++; $display("FAIL sb_ctrl got wr %b size %0d expected 1 0", ob_hwrite, ob_hsize); end
    tests++; if (ob_lat !== 6 || ob_rdata !== 32'h0 || ob_err !== 1'b0) begin
      fails++; $display("FAIL sb_resp got lat %0d rdata %h err %b expected 6 0 0", ob_lat, ob_rdata, ob_err); end
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 32'h1002, 32'h0, 3'b010, 0, 1'b0, 32'h1234_5678);
    tests++; if (ob_lat !== 1 || ob_err !== 1'b1 || ob_hs_first !== -1 || ob_rdata !== 32'h0) begin
      fails++; $display("FAIL misaligned_lw got lat %0d err %b hsel@%0d rdata %h expected 1 1 -1 0", ob_lat, ob_err, ob_hs_first, ob_rdata); end
    run_txn(1'b0, 32'h40, 32'h0, 3'b011, 0, 1'b0, 32'h1234_5678);
    tests++; if (ob_lat !== 1 || ob_err !== 1'b1 || ob_hs_first !== -1) begin
      fails++; $display("FAIL bad_rwtyp got lat %0d err %b hsel@%0d expected 1 1 -1", ob_lat, ob_err, ob_hs_first); end
    run_txn(1'b1, 32'h40, 32'h77, 3'b100, 0, 1'b0, 32'h0);
    tests++; if (ob_lat !== 1 || ob_err !== 1'b1 || ob_hs_first !== -1) begin
      fails++; $display("FAIL store_bu got lat %0d err %b hsel@%0d expected 1 1 -1", ob_lat, ob_err, ob_hs_first); end
  endtask

  task automatic test_bus_errors();
    run_txn(1'b0, 32'h10, 32'h0, 3'b010, 1, 1'b1, 32'hFFFF_FFFF);
    tests++; if (ob_lat !== 4 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin
      fails++; $display("FAIL hresp got lat %0d err %b rdata %h expected 4 1 0", ob_lat, ob_err, ob_rdata); end
    run_txn(1'b0, 32'h14, 32'h0, 3'b010, 1000, 1'b0, 32'h5555_5555);
    tests++; if (ob_lat !== 2 + TO || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin
      fails++; $display("FAIL timeout got lat %0d err %b rdata %h expected %0d 1 0", ob_lat, ob_err, ob_rdata, 2 + TO); end
    tests++; if (ob_hs_last !== 1 + TO) begin
      fails++; $display("FAIL timeout_hsel got last hsel cycle %0d expected %0d", ob_hs_last, 1 + TO); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          seen;
    seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h44; bus.req_rwtyp = 3'b010;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.hready = 1'b0;
    @(negedge clk);
    tests++; if (bus.hsel !== 1'b1) begin fails++; $display("FAIL midrst_pre got hsel %b expected 1", bus.hsel); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({bus.hsel, bus.hwrite, bus.rsp_valid, bus.rsp_err} !== 4'b0000 ||
                 {bus.haddr, bus.hsize, bus.hwdata, bus.rsp_rdata} !== 99'h0) begin
      fails++; $display("FAIL midrst_async got hsel %b haddr %h rsp %b expected all 0", bus.hsel, bus.haddr, bus.rsp_valid); end
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    rst = 1'b0; bus.hready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_rsp got %0d pulses expected 0", seen); end
    rd = $urandom;
    run_txn(1'b0, 32'h48, 32'h0, 3'b010, 0, 1'b0, rd);
    tests++; if (ob_lat !== 3 || ob_rdata !== rd || ob_err !== 1'b0) begin
      fails++; $display("FAIL midrst_after got lat %0d rdata %h err %b expected 3 %h 0", ob_lat, ob_rdata, ob_err, rd); end
  endtask

  // Held request: accepted again as soon as IDLE returns, ignored during RESP
  task automatic test_back_to_back();
    logic [5:0] got;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_rwtyp = 3'b011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      got[c - 1] = bus.rsp_valid;
      if (c == 6) bus.req_valid = 1'b0;
    end
    tests++; if (got !== 6'b010101) begin fails++; $display("FAIL back_to_back got %b expected 010101", got); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        e;
    logic        we, resp_e;
    logic [31:0] addr, wdata, rd;
    logic [2:0]  typ;
    int          r, waits, nb;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 14) begin
        case (r % 5)
          0: typ = 3'b000; 1: typ = 3'b001; 2: typ = 3'b010; 3: typ = 3'b100; default: typ = 3'b101;
        endcase
      end else begin
        case ($urandom_range(0, 2))
          0: typ = 3'b011; 1: typ = 3'b110; default: typ = 3'b111;
        endcase
      end
      we     = 1'($urandom_range(0, 1));
      addr   = $urandom;
      nb     = 1 << (typ % 4);
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
      wdata  = $urandom;
      rd     = $urandom;
      waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      resp_e = ($urandom_range(0, 7) == 0);
      e = model(we, addr, wdata, typ, waits, resp_e, rd);
      run_txn(we, addr, wdata, typ, waits, resp_e, rd);
      tests++; if (ob_lat !== e.lat) begin
        fails++; $display("FAIL rnd%0d_latency got %0d expected %0d", i, ob_lat, e.lat); end
      tests++; if (ob_rdata !== e.rdata || ob_err !== e.err) begin
        fails++; $display("FAIL rnd%0d_resp got %h/%b expected %h/%b", i, ob_rdata, ob_err, e.rdata, e.err); end
      tests++; if (ob_nvalid !== 1 || ob_hold !== 1'b1 || ob_ready !== 1'b1) begin
        fails++; $display("FAIL rnd%0d_handshake got cnt %0d hold %b ready %b expected 1 1 1", i, ob_nvalid, ob_hold, ob_ready); end
      if (e.illegal) begin
        tests++; if (ob_hs_first !== -1) begin
          fails++; $display("FAIL rnd%0d_nobus got hsel@%0d expected none", i, ob_hs_first); end
      end else begin
        tests++; if (ob_hs_first !== 1 || ob_hs_last !== e.lat - 1) begin
          fails++; $display("FAIL rnd%0d_hsel got %0d..%0d expected 1..%0d", i, ob_hs_first, ob_hs_last, e.lat - 1); end
        tests++; if (ob_haddr !== addr || ob_hwrite !== we || ob_hsize !== 3'(typ % 4)) begin
          fails++; $display("FAIL rnd%0d_addr got %h/%b/%0d expected %h/%b/%0d", i, ob_haddr, ob_hwrite, ob_hsize, addr, we, typ % 4); end
        if (we) begin
          tests++; if (ob_hwdata !== e.hwdata) begin
            fails++; $display("FAIL rnd%0d_hwdata got %h expected %h", i, ob_hwdata, e.hwdata); end
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store_wait();
    test_illegal();
    test_bus_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/ahb_lsu_master.md
Name: ahb_lsu_master

Overview:
- AHB-lite initiator that turns single load/store requests from the core LSU into one AHB transfer each.
- Pairs with the RAM-side AHB responder (hsel/haddr/hwrite/hwdata in; hready/hresp/hrdata out) and drives those signals.
- Handles byte-lane placement for stores, extraction and sign/zero extension for loads, alignment checks, and a bus timeout.
- Sits between the core data port and the AHB interconnect. One outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and haddr.
- DATA_WIDTH, 32, bus data width. Lane logic is defined for 32 only.
- TIMEOUT, 255, number of DATA-phase cycles with hready=0 before the transfer is abandoned with an error. Must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request (IDLE only).
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rwtyp  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and on error.
- rsp_err  out  1  response is an error; valid with rsp_valid.
- hsel  out  1  slave select.
- haddr  out  ADDR_WIDTH  transfer address (full byte address).
- hwrite  out  1  transfer direction.
- hsize  out  3  0=byte, 1=half, 2=word.
- hwdata  out  32  lane-replicated store data.
- hready  in  1  slave ready.
- hresp  in  1  slave error.
- hrdata  in  32  aligned word read from the slave.

Behaviour:
- States: IDLE, ADDR, DATA, RESP. Every output is registered.
- Reset (asynchronous, any state):
  - state=IDLE.
  - hsel, hwrite, haddr, hsize, hwdata, rsp_valid, rsp_rdata, rsp_err all 0; timeout counter 0.
  - req_ready=1 after reset releases.
  - Reset mid-transfer aborts the transfer with no response and drops hsel immediately.
- IDLE:
  - req_ready=1. Accept on req_valid & req_ready at edge T.
  - Illegal request, go to RESP with rsp_err=1 and no bus access (hsel stays 0). Illegal means either:
    - rwtyp not one of {000,001,010,100,101};
    - stores with rwtyp 100 or 101;
    - misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Legal request: go to ADDR. In cycle T+1: hsel=1, haddr=req_addr, hwrite=req_we, hsize=rwtyp[1:0].
- ADDR:
  - Lasts exactly one cycle, then DATA.
  - For stores, hwdata is loaded on entry to DATA:
    - B: replicate wdata[7:0] into all 4 bytes.
    - H: replicate wdata[15:0] into both halves.
    - W: wdata unchanged.
  - hsel, haddr, hwrite and hsize are held unchanged through DATA.
- DATA:
  - Sample hready every edge. While hready=0, the counter increments.
  - hready=1 with hresp=1: go to RESP with rsp_err=1, rsp_rdata=0.
  - hready=1 with hresp=0, load: rsp_rdata = byte or half selected by haddr[1:0] (haddr[1] for halves), sign-extended for B/H and zero-extended for BU/HU. W passes the word unchanged.
  - hready=1 with hresp=0, store: rsp_rdata=0.
  - Counter reaches TIMEOUT with hready still 0: go to RESP with rsp_err=1.
  - On exit from DATA: hsel=0, hwrite=0, counter=0.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0.
  - Next state IDLE. rsp_rdata and rsp_err hold until the next response.
- Latency:
  - Legal transfer, zero wait states: rsp_valid in cycle T+3.
  - Each wait cycle adds 1.
  - Illegal request: rsp_valid in cycle T+1.
- req_valid while not IDLE is ignored; the core must hold its request until accepted.
- hrdata and hresp are sampled only in DATA when hready=1.

Test Plan:
- LW 0x100, hrdata=0x89ABCDEF, hready=1 at once → hsel high for T+1..T+2, hsize=2; rsp_valid at T+3, rsp_rdata=0x89ABCDEF, rsp_err=0.
- LB 0x203, hrdata=0x80112233 → rsp_rdata=0xFFFFFF80. LHU 0x202, same hrdata → rsp_rdata=0x00008011.
- SB 0x301, wdata=0x000000A5, with 3 wait cycles → hwdata=0xA5A5A5A5, hwrite=1, hsize=0; rsp_valid at T+6, rsp_rdata=0.
- Two invalid requests, each with no hsel activity and rsp_valid+rsp_err at T+1:
  - LW 0x1002 (misaligned);
  - rwtyp=011 (illegal encoding).
- hresp=1 with hready=1 → rsp_err=1, rsp_rdata=0. Separately, hready held 0 with TIMEOUT=4 → rsp_err=1 after 4 DATA cycles, hsel drops.
- Assert rst during DATA → all outputs 0 asynchronously, no rsp_valid. A new LW after reset completes normally.
